// File: rtl/reg8_rr_arbiter_pkg.sv
// Shared definitions for the register-sharing round-robin arbiter.
//   arb_state_t : arbiter FSM states (ARB = free arbitration, LOCKED = owner held)
//   NREQ_MAX    : largest supported requester count
//   IDXW        : index width for the generic helpers (covers NREQ_MAX)
//   onehot()    : index -> one-hot vector, NREQ_MAX bits wide; callers truncate
package reg8_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned IDXW     = $clog2(NREQ_MAX);

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ_MAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg8_rr_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
//   req      : per-requester write request
//   lock     : per-requester request to keep ownership
//   wdata    : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      : registered one-hot grant of the write just performed
//   owner    : index of last granted requester
//   wr_valid : registered, high one cycle per write
//   q        : shared register contents
// master = requester logic, slave = arbiter.
interface reg8_rr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         owner;
  logic                  wr_valid;
  logic [WIDTH-1:0]      q;

  modport master (output req, lock, wdata, input gnt, owner, wr_valid, q);
  modport slave  (input req, lock, wdata, output gnt, owner, wr_valid, q);
endinterface

// File: rtl/reg8_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : index of the previous winner; scan starts at ptr_i+1
//   excl_i   : requesters removed from this pick
//   found_o  : some non-excluded request present
//   winner_o : first set request scanning ptr_i+1, ptr_i+2, ... modulo NREQ
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  input  logic [NREQ-1:0]         excl_i,
  output logic                    found_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] m;
  int unsigned     idx;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    m        = req_i & ~excl_i;
    // Modulo keeps indices below NREQ, so non-power-of-2 counts never alias.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!found_o && m[idx]) begin
        found_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/reg8_rr_arbiter.sv
// Shared WIDTH-bit synchronous register with round-robin write arbitration
// and bounded bus lock.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of reg8_rr_arbiter_if (req/lock/wdata in,
//           gnt/owner/wr_valid/q out)
module reg8_rr_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  reg8_rr_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             wr_q, wr_d;

  logic [NREQ-1:0]  owner_oh, excl;
  logic             cnt_max, hold, found, wr_en;
  logic [IW-1:0]    pick, win;

  assign owner_oh = NREQ'(onehot(IDXW'(owner_q)));
  assign cnt_max  = (cnt_q >= CW'(LOCK_MAX));
  assign hold     = (state_q == LOCKED) && bus.req[owner_q] && !cnt_max;
  // Forced release skips the owner only when someone else is waiting.
  assign excl     = ((state_q == LOCKED) && cnt_max && |(bus.req & ~owner_oh))
                    ? owner_oh : '0;

  // ptr_q always equals the last winner, so it also serves as ptr=owner
  // when a lock ends.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .excl_i   (excl),
    .found_o  (found),
    .winner_o (pick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB;
      cnt_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ARB;
    cnt_d   = '0;
    wr_en   = 1'b0;
    win     = owner_q;
    if (hold) begin
      wr_en   = 1'b1;
      win     = owner_q;
      if (bus.lock[owner_q]) begin
        state_d = LOCKED;
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (found) begin
      wr_en = 1'b1;
      win   = pick;
      if (bus.lock[pick]) begin
        state_d = LOCKED;
        cnt_d   = CW'(1);
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    q_d     = q_q;
    gnt_d   = '0;
    wr_d    = 1'b0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (wr_en) begin
      q_d     = bus.wdata[int'(win)*WIDTH +: WIDTH];
      gnt_d   = NREQ'(onehot(IDXW'(win)));
      wr_d    = 1'b1;
      owner_d = win;
      ptr_d   = win;
    end
  end

  assign bus.q        = q_q;
  assign bus.gnt      = gnt_q;
  assign bus.wr_valid = wr_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_reg8_rr_arbiter.sv
module tb_reg8_rr_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg8_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  reg8_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        wr;
    logic [7:0]  q;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [31:0] WD  = 32'h4433_2211;
  localparam logic [31:0] WD9 = 32'h4433_2299;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] lk, logic [31:0] wd,
                              logic [3:0] g, logic [1:0] o, logic w, logic [7:0] qq);
    vec_t v;
    v.rst_n = r; v.req = rq; v.lock = lk; v.wdata = wd;
    v.gnt = g; v.owner = o; v.wr = w; v.q = qq;
    return v;
  endfunction

  initial begin
    vec_t e;
    // reset, then idle
    repeat (2) vecs.push_back(mk(0, 4'b0000, 4'b0000, WD, 4'b0000, 0, 0, 8'h00));
    repeat (3) vecs.push_back(mk(1, 4'b0000, 4'b0000, WD, 4'b0000, 0, 0, 8'h00));
    // all requesting, plain rotation from requester 0
    vecs.push_back(mk(1, 4'b1111, 4'b0000, WD, 4'b0001, 0, 1, 8'h11));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, WD, 4'b0010, 1, 1, 8'h22));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, WD, 4'b0100, 2, 1, 8'h33));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, WD, 4'b1000, 3, 1, 8'h44));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, WD, 4'b0001, 0, 1, 8'h11));
    // 0 and 2 alternate, pointer wraps
    repeat (2) begin
      vecs.push_back(mk(1, 4'b0101, 4'b0000, WD, 4'b0100, 2, 1, 8'h33));
      vecs.push_back(mk(1, 4'b0101, 4'b0000, WD, 4'b0001, 0, 1, 8'h11));
    end
    // requester 1 locks with 3 waiting: LOCK_MAX grants, then forced release to 3
    repeat (LOCK_MAX) vecs.push_back(mk(1, 4'b1010, 4'b0010, WD, 4'b0010, 1, 1, 8'h22));
    vecs.push_back(mk(1, 4'b1010, 4'b0010, WD, 4'b1000, 3, 1, 8'h44));
    vecs.push_back(mk(1, 4'b1010, 4'b0010, WD, 4'b0010, 1, 1, 8'h22));
    // locked owner drops req, nobody else: idle, q holds
    vecs.push_back(mk(1, 4'b0000, 4'b0000, WD, 4'b0000, 1, 0, 8'h22));
    // requester 2 locked for 2 grants, drops; 3 granted with no bubble
    repeat (2) vecs.push_back(mk(1, 4'b1100, 4'b0100, WD, 4'b0100, 2, 1, 8'h33));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, WD, 4'b1000, 3, 1, 8'h44));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, WD, 4'b0000, 3, 0, 8'h44));
    // lock without req ignored
    vecs.push_back(mk(1, 4'b0001, 4'b0010, WD, 4'b0001, 0, 1, 8'h11));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, WD, 4'b0010, 1, 1, 8'h22));
    // single requester toggling; q holds while idle even if wdata changes
    vecs.push_back(mk(1, 4'b0001, 4'b0000, WD,  4'b0001, 0, 1, 8'h11));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, WD9, 4'b0000, 0, 0, 8'h11));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, WD9, 4'b0001, 0, 1, 8'h99));
    // reset in the middle of a lock; pointer returns to NREQ-1
    vecs.push_back(mk(1, 4'b0010, 4'b0010, WD, 4'b0010, 1, 1, 8'h22));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, WD, 4'b0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'b1010, 4'b0000, WD, 4'b0010, 1, 1, 8'h22));

    reset     = 1'b0;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst_n;
      bus.req   = vecs[i].req;
      bus.lock  = vecs[i].lock;
      bus.wdata = vecs[i].wdata;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (bus.gnt !== e.gnt) begin
        n_miss++;
        $display("FAIL vec%0d gnt: got %b want %b", i, bus.gnt, e.gnt);
      end
      if (bus.wr_valid !== e.wr) begin
        n_miss++;
        $display("FAIL vec%0d wr_valid: got %b want %b", i, bus.wr_valid, e.wr);
      end
      if (bus.wr_valid !== (|bus.gnt)) begin
        n_miss++;
        $display("FAIL vec%0d wr_valid_vs_gnt: got %b want %b", i, bus.wr_valid, |bus.gnt);
      end
      if (bus.owner !== e.owner) begin
        n_miss++;
        $display("FAIL vec%0d owner: got %0d want %0d", i, bus.owner, e.owner);
      end
      if (bus.q !== e.q) begin
        n_miss++;
        $display("FAIL vec%0d q: got %h want %h", i, bus.q, e.q);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/reg8_rr_arbiter.md
Name: reg8_rr_arbiter

Overview:
- Shares one WIDTH-bit synchronous storage register (same behaviour as the team's 8-bit synchronous D register) between NREQ requesters.
- Round-robin arbitration; optional bounded bus lock lets one requester keep ownership for consecutive writes.
- Sits between requester logic and the shared register; the register lives inside this block, and `q` is its output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data/register width.
- LOCK_MAX, 4, maximum consecutive grants to one locked owner before forced release (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester write request.
- lock  input  NREQ  per-requester request to keep ownership next cycle.
- wdata  input  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant for the write just performed; all zero when no write.
- owner  output  $clog2(NREQ)  index of last granted requester.
- wr_valid  output  1  registered; high for one cycle per write performed.
- q  output  WIDTH  shared register contents.

Behaviour:
- Reset:
  - Sampled on clk rising edge when reset==0; overrides all other activity, including a locked transfer in progress.
  - After reset: q=0, gnt=0, wr_valid=0, owner=0, state=ARB, lock_cnt=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has top priority first.
- Arbitration (state ARB):
  - At each edge, if any req bit is set, the winner w is the first set req scanning ptr+1, ptr+2, ... modulo NREQ.
  - At that same edge: q<=wdata[w], gnt<=onehot(w), wr_valid<=1, owner<=w, ptr<=w.
  - Latency: the request sampled at edge t is written and visible on q/gnt after edge t. No extra cycle.
  - If req==0: gnt<=0, wr_valid<=0, q holds, ptr holds.
- Lock:
  - If the winner w also has lock[w]==1 at the grant edge, state<=LOCKED and lock_cnt<=1.
  - LOCKED, req[owner]==1 and lock_cnt<LOCK_MAX:
    - owner is granted again regardless of other requests; q<=wdata[owner], gnt/wr_valid as above.
    - lock_cnt increments.
    - Stay LOCKED if lock[owner]==1, else go to ARB.
  - LOCKED, req[owner]==0: no write by owner; go to ARB. Arbitration runs in that same cycle among the other requesters, with ptr=owner, so no idle bubble occurs.
  - LOCKED, lock_cnt==LOCK_MAX: forced release. Arbitrate in that cycle as in ARB, with the owner excluded if any other req is set. Then lock_cnt<=0. A new lock by the new winner is honoured normally.
- Invariants:
  - gnt is always zero or one-hot.
  - wr_valid == |gnt.
  - q changes only on an edge where wr_valid is set.
- Wrap-around: ptr wraps modulo NREQ; for non-power-of-2 NREQ, indices >=NREQ are never selected.
- Simultaneous events:
  - A req and lock from a non-owner while LOCKED are ignored (not queued); the requester must hold req.
  - lock without req is ignored.
- X-safety: wdata of non-winning requesters never reaches q.

Decomposition:
- Package reg8_arb_pkg:
  - arb_state_t enum {ARB, LOCKED}.
  - Function onehot(idx).
  - Localparam IDXW = $clog2(NREQ).
- Sub-module rr_pick (combinational): inputs req, ptr, exclude mask; outputs found and winner index. Reusable by future arbiters.
- The storage register is inline; it must not depend on the existing asynchronous-free D-register module's reset polarity.

Test Plan:
- Reset, then req=4'b0000 for 3 cycles -> q=8'h00, gnt=0, wr_valid=0. Drive reset=0 mid-lock -> next edge q=0, state ARB.
- req=4'b1111, wdata={8'h44,8'h33,8'h22,8'h11}, no lock, 5 cycles -> gnt sequence 0001,0010,0100,1000,0001; q sequence 11,22,33,44,11.
- req=4'b0101 constant, no lock -> gnt alternates 0001/0100; q alternates wdata0/wdata2; ptr wraps correctly.
- Requester 1 with req=1, lock=1 held; requester 3 with req=1; LOCK_MAX=4 -> gnt=0010 for 4 consecutive cycles, then 1000. Requester 3 is never starved beyond LOCK_MAX cycles.
- Requester 2 locked, drops req after 2 grants while req3=1 -> the next edge grants 3 with no idle cycle; wr_valid stays high.
- Single requester 0 toggling req 1,0,1 -> wr_valid 1,0,1; q holds its value during the 0 cycle.
